// File: rtl/ram_pkg.sv
// ram_pkg
//   Shared sizing helpers and types for the byte-write data RAM.
//   Lane count, address offset and index width are derived from the
//   top-level parameters through the functions below, so every file
//   computes them the same way.
//     nb_of(dw)     : byte lanes per word (DW/8)
//     ofs_of(dw)    : byte-offset bits dropped from an address (clog2(NB))
//     iw_of(n)      : word-index width for an n-deep array (at least 1)
//     cfg_ok(...)   : legality of a DW / RD_LAT / MEM_NUM combination
//     rd_tag_t      : per-stage read status (valid, out-of-range/zero)
package ram_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int nb_of(input int dw);
        return dw / 8;
    endfunction

    function automatic int ofs_of(input int dw);
        return clog2(dw / 8);
    endfunction

    // A one-word array still needs a 1-bit index port.
    function automatic int iw_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic bit cfg_ok(input int dw, input int rd_lat, input int mem_num);
        return (dw % 8 == 0) && (dw >= 8) && (dw <= 128) &&
               ((rd_lat == 1) || (rd_lat == 2)) && (mem_num >= 1);
    endfunction

    // oor doubles as "force the data path to zero": it is set both for an
    // out-of-range read and out of reset, so held r_data reads 0.
    typedef struct packed {
        logic vld;
        logic oor;
    } rd_tag_t;

endpackage

// File: rtl/ram_lane.sv
// ram_lane
//   One 8-bit byte lane: DEPTH-deep simple-dual-port storage with a write
//   port and a registered read port. A read and write to the same entry on
//   the same edge returns the old contents; forwarding is handled above.
//   Ports:
//     clk    : clock
//     we     : write strobe for this lane
//     w_idx  : write word index
//     w_byte : write data
//     re     : read strobe; r_byte only changes when re is high
//     r_idx  : read word index
//     r_byte : registered read data
module ram_lane
    import ram_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IW    = iw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] w_idx,
    input  logic [7:0]    w_byte,
    input  logic          re,
    input  logic [IW-1:0] r_idx,
    output logic [7:0]    r_byte
);

    logic [7:0] mem [DEPTH];

    // No reset on the array or the read register: contents are undefined
    // until written, and the top masks r_byte until a real read lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_idx] <= w_byte;
        end
        if (re) begin
            r_byte <= mem[r_idx];
        end
    end

endmodule

// File: rtl/ram_bw.sv
// ram_bw
//   Parametrised byte-write simple-dual-port data RAM built from NB byte
//   lanes. Reads return after RD_LAT (1 or 2) cycles with an r_valid strobe;
//   out-of-range accesses are flagged. Same-cycle same-word read/write can
//   forward the new bytes (WR_FWD=1) or return the old word (WR_FWD=0).
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     wen             : per-byte write enables (DW/8 bits)
//     w_addr, w_data  : write byte address (low OFS bits ignored), data
//     w_err           : one-cycle flag, previous write was out of range
//     ren, r_addr     : read request and byte address
//     r_data          : read data, held while r_valid is low
//     r_valid, r_err  : read strobe and its out-of-range qualifier
module ram_bw
    import ram_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_NUM = 4096,
    parameter int RD_LAT  = 1,
    parameter int WR_FWD  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW/8-1:0]   wen,
    input  logic [AW-1:0]     w_addr,
    input  logic [DW-1:0]     w_data,
    output logic              w_err,
    input  logic              ren,
    input  logic [AW-1:0]     r_addr,
    output logic [DW-1:0]     r_data,
    output logic              r_valid,
    output logic              r_err
);

    localparam int NB  = nb_of(DW);
    localparam int OFS = ofs_of(DW);
    localparam int IW  = iw_of(MEM_NUM);

    // One extra bit so the compare stays correct when MEM_NUM == 2**AW.
    localparam logic [AW:0] LIMIT = (AW+1)'(MEM_NUM);

    generate
        if (!cfg_ok(DW, RD_LAT, MEM_NUM)) begin : g_bad_cfg
            $error("ram_bw: illegal configuration (DW must be 8..128 in steps of 8, RD_LAT 1 or 2, MEM_NUM >= 1)");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Address decode and range check. The whole word index, including the
    // upper address bits, takes part in the compare.
    // ------------------------------------------------------------------
    logic [AW-1:0] w_word;
    logic [AW-1:0] r_word;
    logic          w_ok;
    logic          r_ok;
    logic          w_act;
    logic          r_act;
    logic          same_word;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] r_idx;

    assign w_word    = w_addr >> OFS;
    assign r_word    = r_addr >> OFS;
    assign w_ok      = {1'b0, w_word} < LIMIT;
    assign r_ok      = {1'b0, r_word} < LIMIT;
    assign w_act     = !rst && (|wen) && w_ok;
    assign r_act     = !rst && ren && r_ok;
    assign same_word = (w_word == r_word);
    assign w_idx     = w_word[IW-1:0];
    assign r_idx     = r_word[IW-1:0];

    // ------------------------------------------------------------------
    // Byte lanes
    // ------------------------------------------------------------------
    logic [DW-1:0] lane_q;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        ram_lane #(
            .DEPTH (MEM_NUM),
            .IW    (IW)
        ) u_lane (
            .clk    (clk),
            .we     (w_act & wen[i]),
            .w_idx  (w_idx),
            .w_byte (w_data[8*i +: 8]),
            .re     (r_act),
            .r_idx  (r_idx),
            .r_byte (lane_q[8*i +: 8])
        );
    end

    // ------------------------------------------------------------------
    // Stage 1: captured alongside the lane read registers. The side-band
    // only moves on a read, so with lane_q (which also only moves on a
    // read) the stage-1 word holds its last value between reads.
    // ------------------------------------------------------------------
    rd_tag_t       s1_tag;
    logic [NB-1:0] s1_fwd;
    logic [DW-1:0] s1_wdata;
    logic [DW-1:0] s1_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_tag   <= '{vld: 1'b0, oor: 1'b1};
            s1_fwd   <= '0;
            s1_wdata <= '0;
        end else begin
            s1_tag.vld <= ren;
            if (ren) begin
                s1_tag.oor <= !r_ok;
                // w_act with same_word already implies the read is in range.
                s1_fwd     <= ((WR_FWD != 0) && w_act && same_word) ? wen : '0;
                s1_wdata   <= w_data;
            end
        end
    end

    always_comb begin
        s1_word = '0;
        for (int i = 0; i < NB; i++) begin
            s1_word[8*i +: 8] = s1_fwd[i] ? s1_wdata[8*i +: 8] : lane_q[8*i +: 8];
        end
        if (s1_tag.oor) begin
            s1_word = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (RD_LAT == 2) begin : g_lat2
            rd_tag_t       s2_tag;
            logic [DW-1:0] s2_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_tag  <= '{vld: 1'b0, oor: 1'b0};
                    s2_data <= '0;
                end else begin
                    s2_tag.vld <= s1_tag.vld;
                    s2_tag.oor <= s1_tag.vld & s1_tag.oor;
                    if (s1_tag.vld) begin
                        s2_data <= s1_word;
                    end
                end
            end

            assign r_data  = s2_data;
            assign r_valid = s2_tag.vld;
            assign r_err   = s2_tag.vld & s2_tag.oor;
        end else begin : g_lat1
            assign r_data  = s1_word;
            assign r_valid = s1_tag.vld;
            assign r_err   = s1_tag.vld & s1_tag.oor;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_err <= 1'b0;
        end else begin
            w_err <= (|wen) && !w_ok;
        end
    end

endmodule

// File: tb/tb_ram_bw.sv
// tb_ram_bw
//   Three ram_bw instances checked every cycle against a byte-array
//   reference model:
//     inst 0 : DW=32, MEM_NUM=16, RD_LAT=1, WR_FWD=1
//     inst 1 : DW=32, MEM_NUM=16, RD_LAT=2, WR_FWD=0
//     inst 2 : DW=64, MEM_NUM=16, RD_LAT=2, WR_FWD=1
//   Directed sequences cover the listed scenarios, then random traffic.
module tb_ram_bw;

    localparam int MEMN = 16;

    logic clk;
    logic rst;

    logic [2:0][7:0]  wen;
    logic [2:0][31:0] waddr;
    logic [2:0][31:0] raddr;
    logic [2:0][63:0] wdata;
    logic [2:0]       ren;

    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [63:0] rd2;
    logic [2:0]  rv;
    logic [2:0]  re;
    logic [2:0]  we;

    ram_bw #(.AW(32), .DW(32), .MEM_NUM(MEMN), .RD_LAT(1), .WR_FWD(1)) u_a (
        .clk(clk), .rst(rst), .wen(wen[0][3:0]), .w_addr(waddr[0]), .w_data(wdata[0][31:0]),
        .w_err(we[0]), .ren(ren[0]), .r_addr(raddr[0]), .r_data(rd0), .r_valid(rv[0]), .r_err(re[0]));

    ram_bw #(.AW(32), .DW(32), .MEM_NUM(MEMN), .RD_LAT(2), .WR_FWD(0)) u_b (
        .clk(clk), .rst(rst), .wen(wen[1][3:0]), .w_addr(waddr[1]), .w_data(wdata[1][31:0]),
        .w_err(we[1]), .ren(ren[1]), .r_addr(raddr[1]), .r_data(rd1), .r_valid(rv[1]), .r_err(re[1]));

    ram_bw #(.AW(32), .DW(64), .MEM_NUM(MEMN), .RD_LAT(2), .WR_FWD(1)) u_c (
        .clk(clk), .rst(rst), .wen(wen[2]), .w_addr(waddr[2]), .w_data(wdata[2]),
        .w_err(we[2]), .ren(ren[2]), .r_addr(raddr[2]), .r_data(rd2), .r_valid(rv[2]), .r_err(re[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int nb  [3] = '{4, 4, 8};
    int lat [3] = '{1, 2, 2};
    int fwd [3] = '{1, 0, 1};

    logic [7:0]       mmem [3][MEMN*8];
    logic [2:0]       e_rv;
    logic [2:0]       e_re;
    logic [2:0]       e_we;
    logic [2:0][63:0] e_rd;
    logic [2:0]       p_v;
    logic [2:0]       p_e;
    logic [2:0][63:0] p_d;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_rd(input int k);
        case (k)
            0:       return {32'b0, rd0};
            1:       return {32'b0, rd1};
            default: return rd2;
        endcase
    endfunction

    task automatic model_reset();
        e_rv = '0;
        e_re = '0;
        e_we = '0;
        e_rd = '0;
        p_v  = '0;
        p_e  = '0;
        p_d  = '0;
    endtask

    // Applies the inputs currently driven (the edge about to happen) to the
    // model and computes what the outputs should be after that edge.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int          ofs;
            logic [31:0] widx;
            logic [31:0] ridx;
            bit          wok;
            bit          rok;
            bit          v;
            bit          e;
            logic [63:0] d;
            bit          ov;
            bit          oe;
            logic [63:0] od;
            ofs  = (nb[k] == 8) ? 3 : 2;
            widx = waddr[k] >> ofs;
            ridx = raddr[k] >> ofs;
            wok  = widx < MEMN;
            rok  = ridx < MEMN;
            v    = ren[k];
            e    = 1'b0;
            d    = '0;
            if (ren[k]) begin
                if (!rok) begin
                    e = 1'b1;
                end else begin
                    for (int b = 0; b < nb[k]; b++) begin
                        if (fwd[k] == 1 && wen[k][b] && wok && widx == ridx)
                            d[8*b +: 8] = wdata[k][8*b +: 8];
                        else
                            d[8*b +: 8] = mmem[k][ridx*nb[k] + b];
                    end
                end
            end
            if (wen[k] != 0 && wok) begin
                for (int b = 0; b < nb[k]; b++) begin
                    if (wen[k][b]) mmem[k][widx*nb[k] + b] = wdata[k][8*b +: 8];
                end
            end
            e_we[k] = (wen[k] != 0) && !wok;
            if (lat[k] == 1) begin
                ov = v; oe = e; od = d;
            end else begin
                ov = p_v[k]; oe = p_e[k]; od = p_d[k];
                p_v[k] = v; p_e[k] = e; p_d[k] = d;
            end
            e_rv[k] = ov;
            e_re[k] = ov & oe;
            if (ov) e_rd[k] = od;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("r_valid[%0d]", k), {63'b0, rv[k]}, {63'b0, e_rv[k]});
            check_val($sformatf("r_err[%0d]", k),   {63'b0, re[k]}, {63'b0, e_re[k]});
            check_val($sformatf("w_err[%0d]", k),   {63'b0, we[k]}, {63'b0, e_we[k]});
            check_val($sformatf("r_data[%0d]", k),  dut_rd(k), e_rd[k]);
        end
    endtask

    task automatic idle_inputs();
        wen   = '0;
        ren   = '0;
        waddr = '0;
        raddr = '0;
        wdata = '0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_wr(input int k, input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
        waddr[k] = a;
        wen[k]   = (nb[k] == 8) ? m : (m & 8'h0F);
        wdata[k] = d;
    endtask

    task automatic set_rd(input int k, input logic [31:0] a);
        raddr[k] = a;
        ren[k]   = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr(input int k);
        logic [31:0] a;
        a = $urandom_range(0, (MEMN + 2) * nb[k] - 1);
        if ($urandom_range(0, 19) == 0) a[31] = 1'b1;
        return a;
    endfunction

    // Async reset asserted mid-cycle; random traffic during it must be ignored.
    task automatic do_reset();
        for (int k = 0; k < 3; k++) begin
            wen[k]   = 8'($urandom);
            ren[k]   = 1'b1;
            waddr[k] = rnd_addr(k);
            raddr[k] = rnd_addr(k);
            wdata[k] = {$urandom, $urandom};
        end
        wen[0][7:4] = '0;
        wen[1][7:4] = '0;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        idle_inputs();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Preload every word of every instance.
        for (int w = 0; w < MEMN; w++) begin
            idle_inputs();
            for (int k = 0; k < 3; k++) set_wr(k, w * nb[k], 8'hFF, {$urandom, $urandom});
            step();
        end

        // Full then partial write, read at an unaligned byte address.
        idle_inputs(); set_wr(0, 32'h10, 8'h0F, 64'hDEADBEEF); step();
        idle_inputs(); set_wr(0, 32'h10, 8'h01, 64'h000000AA); step();
        idle_inputs(); set_rd(0, 32'h13); step();
        check_val("partial_data", {32'b0, rd0}, 64'hDEADBEAA);
        check_val("partial_vld", {63'b0, rv[0]}, 64'd1);
        idle_inputs(); step();
        check_val("partial_pulse", {63'b0, rv[0]}, 64'd0);

        // Same-cycle same-word forwarding, on (inst 0) and off (inst 1).
        idle_inputs();
        set_wr(0, 32'h20, 8'h0F, 64'h11223344);
        set_wr(1, 32'h20, 8'h0F, 64'h11223344);
        step();
        idle_inputs();
        set_wr(0, 32'h20, 8'h0A, 64'hAABBCCDD); set_rd(0, 32'h20);
        set_wr(1, 32'h20, 8'h0A, 64'hAABBCCDD); set_rd(1, 32'h20);
        step();
        check_val("fwd_on", {32'b0, rd0}, 64'hAA22CC44);
        idle_inputs(); step();
        check_val("fwd_off", {32'b0, rd1}, 64'h11223344);
        check_val("fwd_off_vld", {63'b0, rv[1]}, 64'd1);

        // RD_LAT=2 streaming of words 0..3.
        for (int w = 0; w < 4; w++) begin
            idle_inputs(); set_wr(1, w * 4, 8'h0F, 64'(w)); step();
        end
        idle_inputs(); step();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i < 4) set_rd(1, i * 4);
            step();
            if (i >= 1 && i <= 4) begin
                check_val("stream_vld", {63'b0, rv[1]}, 64'd1);
                check_val("stream_data", {32'b0, rd1}, 64'(i - 1));
            end else begin
                check_val("stream_idle", {63'b0, rv[1]}, 64'd0);
            end
        end

        // Out-of-range write and read (index 16 of 16).
        idle_inputs(); set_wr(0, 32'h40, 8'h01, 64'h55); step();
        check_val("werr_set", {63'b0, we[0]}, 64'd1);
        idle_inputs(); step();
        check_val("werr_pulse", {63'b0, we[0]}, 64'd0);
        idle_inputs(); set_rd(0, 32'h40); step();
        check_val("oor_vld", {63'b0, rv[0]}, 64'd1);
        check_val("oor_err", {63'b0, re[0]}, 64'd1);
        check_val("oor_data", {32'b0, rd0}, 64'd0);
        idle_inputs(); set_rd(0, 32'h0); step();

        // Reset with a read in flight on the 2-cycle pipeline.
        idle_inputs(); set_rd(1, 32'h8); step();
        do_reset();
        idle_inputs(); step();
        idle_inputs(); step();
        check_val("rst_drop", {63'b0, rv[1]}, 64'd0);
        check_val("rst_zero", {32'b0, rd1}, 64'd0);
        idle_inputs(); set_rd(1, 32'h8); step();
        idle_inputs(); step();
        check_val("rst_reread_vld", {63'b0, rv[1]}, 64'd1);

        // 64-bit: single top-lane write, read back via an unaligned address.
        idle_inputs(); set_wr(2, 32'h8, 8'hFF, 64'h0123456789ABCDEF); step();
        idle_inputs(); set_wr(2, 32'h8, 8'h80, 64'hA500000000000000); step();
        idle_inputs(); set_rd(2, 32'hF); step();
        idle_inputs(); step();
        check_val("dw64_lane7", rd2, 64'hA523456789ABCDEF);

        // Random traffic with a reset in the middle.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            for (int k = 0; k < 3; k++) begin
                logic [7:0] m;
                m = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                set_wr(k, rnd_addr(k), m, {$urandom, $urandom});
                raddr[k] = ($urandom_range(0, 2) == 0) ? waddr[k] : rnd_addr(k);
                ren[k]   = ($urandom_range(0, 9) < 7);
            end
            step();
        end

        idle_inputs();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
